// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the counter-width helper.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  // Wide enough to hold MUL_LAT-1 and WIDTH-1; never narrower than one bit.
  function automatic int MDU_CNT_W(input int mul_lat, input int width);
    int m;
    m = (mul_lat > width) ? mul_lat : width;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Issue/readback bus between the E stage and the multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             req;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_hi;
  logic [WIDTH-1:0] rd_data;
  logic             busy;

  modport master (output req, start, op, src_a, src_b, rd_hi,
                  input  rd_data, busy);
  modport slave  (input  req, start, op, src_a, src_b, rd_hi,
                  output rd_data, busy);
endinterface

// File: rtl/mdu_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per enabled step,
// WIDTH steps after load yield the final quotient and remainder.
module mdu_div_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;

  // quo doubles as the dividend shift register; its MSB feeds the remainder.
  always_comb trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvs <= '0;
      quo <= '0;
      rem <= '0;
    end else if (load) begin
      dvs <= divisor;
      quo <= dividend;
      rem <= '0;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MIPS multiply/divide unit; HI/LO only change when an operation
// completes, so rd_data never exposes partial results.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int CNT_W = MDU_CNT_W(MUL_LAT, WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo, opa, opb;
  logic               mul_sgn, neg_q, neg_r, dz, busy_q;
  logic               accept, is_div, sgn_div, a_neg, b_neg;
  logic [WIDTH-1:0]   amag, bmag, quo, rem;
  logic [2*WIDTH-1:0] ea, eb, prod;

  always_comb begin
    accept  = bus.start & ~bus.req & ~busy_q;
    is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    sgn_div = (bus.op == OP_DIV);
    a_neg   = sgn_div & bus.src_a[WIDTH-1];
    b_neg   = sgn_div & bus.src_b[WIDTH-1];
    amag    = a_neg ? -bus.src_a : bus.src_a;
    bmag    = b_neg ? -bus.src_b : bus.src_b;
    // Sign-extend only for MULT; the 2W-bit modular product is then exact for both.
    ea      = {{WIDTH{mul_sgn & opa[WIDTH-1]}}, opa};
    eb      = {{WIDTH{mul_sgn & opb[WIDTH-1]}}, opb};
    prod    = ea * eb;
  end

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (accept & is_div),
    .step     (state == ST_DIV),
    .dividend (amag),
    .divisor  (bmag),
    .quo      (quo),
    .rem      (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opa     <= '0;
      opb     <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          case (bus.op)
            OP_MTHI: hi <= bus.src_a;
            OP_MTLO: lo <= bus.src_a;
            OP_MULT, OP_MULTU: begin
              opa     <= bus.src_a;
              opb     <= bus.src_b;
              mul_sgn <= (bus.op == OP_MULT);
              cnt     <= CNT_W'(MUL_LAT - 1);
              state   <= ST_MUL;
              busy_q  <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dz     <= (bus.src_b == '0);
              cnt    <= CNT_W'(WIDTH - 1);
              state  <= ST_DIV;
              busy_q <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= prod;
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        ST_DIV: begin
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          // Divide by zero burns the full latency but leaves HI/LO alone.
          if (!dz) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.rd_data = bus.rd_hi ? hi : lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against an arithmetic HI/LO model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int ML = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errs = 0;
  int checks = 0;
  logic [W-1:0] mhi = '0, mlo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_check(input string tag);
    bus.rd_hi = 1'b1; #1;
    chk({tag, " hi"}, 64'(bus.rd_data), 64'(mhi));
    bus.rd_hi = 1'b0; #1;
    chk({tag, " lo"}, 64'(bus.rd_data), 64'(mlo));
  endtask

  // Model update: what HI/LO must hold after the op, and how long busy stays up.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rq, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    if (!rq) begin
      case (op)
        OP_MTHI: mhi = a;
        OP_MTLO: mlo = a;
        OP_MULT: begin
          p = 64'(sa * sb);
          {mhi, mlo} = p;
          lat = ML;
        end
        OP_MULTU: begin
          p = {32'b0, a} * {32'b0, b};
          {mhi, mlo} = p;
          lat = ML;
        end
        OP_DIV: begin
          if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            mlo = W'(q);
            mhi = W'(r);
          end
          lat = W + 1;
        end
        OP_DIVU: begin
          if (b != 0) begin
            mlo = a / b;
            mhi = a % b;
          end
          lat = W + 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic rq);
    int lat, n;
    model(op, a, b, rq, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.req = rq;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.req = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(lat));
    read_check(tag);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         rq;
    int           sel;
    bus.req = 1'b0; bus.start = 1'b0; bus.op = '0;
    bus.src_a = '0; bus.src_b = '0; bus.rd_hi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    read_check("reset");

    run_op("mthi", OP_MTHI, 32'h1234, 32'h0, 1'b0);
    run_op("mtlo", OP_MTLO, 32'hABCD, 32'h0, 1'b0);
    chk("mt hi const", 64'(mhi), 64'h1234);
    run_op("mult -3*7", OP_MULT, -32'sd3, 32'd7, 1'b0);
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div -7/2", OP_DIV, -32'sd7, 32'd2, 1'b0);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("pre hi", OP_MTHI, 32'd1, 32'd0, 1'b0);
    run_op("pre lo", OP_MTLO, 32'd2, 32'd0, 1'b0);
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 1'b0);
    run_op("mult req", OP_MULT, 32'd9, 32'd9, 1'b1);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu by1", OP_DIVU, 32'hDEAD_BEEF, 32'd1, 1'b0);
    run_op("div neg/neg", OP_DIV, -32'sd100, -32'sd7, 1'b0);
    run_op("noop", 3'd7, 32'h5555, 32'h6666, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      b   = (sel == 0) ? '0 : (sel < 4) ? W'($urandom_range(1, 17)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      rq  = ($urandom_range(0, 7) == 0);
      run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, rq);
    end

    // Reset while a divide is mid-flight must clear everything immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    mhi = '0; mlo = '0;
    chk("rst mid busy", 64'(bus.busy), 64'd0);
    read_check("rst mid");
    @(negedge clk) reset = 1'b0;
    run_op("after rst", OP_DIVU, 32'd1000, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core; successor to the fixed-latency 32-bit MDU. Division runs as a real iterative radix-2 restoring divider. Multiplication is a product pipeline with programmable latency. HI/LO are written only at operation completion. The block sits beside the ALU in the E stage: the stall unit reads `busy`, and the M-stage exception logic drives `req` so that a victim instruction cannot start an operation.

## Interface
- `WIDTH`, 32: operand and HI/LO width, ≥ 4, even.
- `MUL_LAT`, 5: multiply busy cycles, ≥ 1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  1  exception/interrupt request; when high, blocks any `start` in the same cycle.
- `start`  in  1  issue strobe for `op`.
- `op`  in  3  operation, encoded per `mdu_pkg` (MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are no-ops).
- `src_a`  in  WIDTH  rs operand: dividend, multiplicand, or MTxx data.
- `src_b`  in  WIDTH  rt operand: divisor or multiplier.
- `rd_hi`  in  1  read select: 1 selects HI, 0 selects LO.
- `rd_data`  out  WIDTH  combinational HI or LO per `rd_hi`; reset value 0.
- `busy`  out  1  an operation is in flight; reset value 0.

## Operation
- Accept condition: `start & ~req & ~busy`. When `busy` is high, `start` is ignored; the stall unit must prevent this case. A `start` carrying a no-op code is accepted and has no effect.
- MTHI/MTLO: the target register is written at the accept edge. `busy` is not raised.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on MULT/MULTU. Operands are latched, and the counter is loaded with MUL_LAT−1.
  - MUL: counts down. At 0, `{HI,LO}` ← product (signed for MULT, unsigned for MULTU, full 2·WIDTH bits), then → IDLE.
  - IDLE → DIV on DIV/DIVU. For signed ops, operand magnitudes and sign flags are latched. The counter is loaded with WIDTH−1.
  - DIV: one restoring step per cycle (shift partial remainder, trial subtract, set quotient bit). At 0 → FIX.
  - FIX: sign correction. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign. Then LO ← quotient, HI ← remainder, → IDLE.
- Divide by zero: full latency is still consumed, and HI/LO are left unchanged.
- Signed DIV of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1) (wraps), HI = 0.
- `req` only gates acceptance. An operation already in flight completes normally.
- `rd_data` reflects the committed HI/LO. It never shows partial results.

## Timing
- Accept at edge T. `busy` is high on cycles T+1 … T+L, then low.
  - L = MUL_LAT for MULT/MULTU.
  - L = WIDTH+1 for DIV/DIVU (33 at WIDTH = 32).
- HI/LO update on the edge that ends the last busy cycle. `rd_data` shows the result in the first cycle after `busy` falls.
- Back-to-back: a new `start` is accepted in the first cycle `busy` is low.
- Reset mid-operation: state → IDLE, `busy` = 0, HI = LO = 0 immediately. The in-flight result is lost.

## Structure
- `mdu_pkg` holds:
  - the `op` encoding constants;
  - the FSM state typedef (2 bits);
  - a `MDU_CNT_W` function, $clog2(max(MUL_LAT, WIDTH)).
- One sub-module, `mdu_div_core`: a restoring divide datapath on unsigned magnitudes (step enable, quotient/remainder outputs). The top level owns the FSM, sign handling, the multiply pipeline and HI/LO.

## Test plan
- Reset, then MTHI 0x1234 and MTLO 0xABCD, `busy` never high → `rd_data` reads HI = 0x00001234, LO = 0x0000ABCD.
- MULT −3 × 7, with WIDTH = 32 and MUL_LAT = 5 → `busy` high exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2 → `busy` high exactly 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 5 / 0 with HI/LO previously 1/2 → 33 busy cycles, then HI/LO unchanged.
- MULT with `start` and `req` both high → `busy` stays 0 and HI/LO are unchanged.
- `reset` asserted at DIV cycle 10 → `busy` and HI/LO are 0 at once.
